// File: rtl/disp_pkg.sv
// Shared definitions for the display scan controller: FSM states,
// default timing parameters and the phase counter width.
package disp_pkg;

   localparam int unsigned CNT_W            = 19;
   localparam int unsigned DEF_PHASE_CYCLES = 120000;
   localparam int unsigned DEF_BLANK_CYCLES = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      DRIVE = 2'd2
   } scan_state_e;

endpackage

// File: rtl/scan_timer.sv
// Loadable phase down-counter; tc marks the final cycle of a loaded interval.
module scan_timer
   import disp_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             tc
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Saturates at zero so an unserviced terminal count never wraps.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc = (cnt_q == '0);

endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexed 4-digit display scanner: blanks, then drives each enabled
// digit in turn for a fixed phase, with a pulse at every frame wrap.
module display_scan_ctrl
   import disp_pkg::*;
#(
   parameter int unsigned PHASE_CYCLES = DEF_PHASE_CYCLES,
   parameter int unsigned BLANK_CYCLES = DEF_BLANK_CYCLES
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [3:0] digit_mask,
   output logic [3:0] an,
   output logic [1:0] sel,
   output logic       blank,
   output logic       frame_tick
);

   localparam logic [CNT_W-1:0] PHASE_LOAD  = CNT_W'(PHASE_CYCLES - 1);
   localparam logic [CNT_W-1:0] BLANK_LOAD  = (BLANK_CYCLES == 0) ? '0 : CNT_W'(BLANK_CYCLES - 1);
   localparam scan_state_e      ENTRY_STATE = (BLANK_CYCLES == 0) ? DRIVE : BLANK;
   localparam logic [CNT_W-1:0] ENTRY_LOAD  = (BLANK_CYCLES == 0) ? PHASE_LOAD : BLANK_LOAD;

   scan_state_e      state_q, state_d;
   logic [1:0]       sel_q, sel_d;
   logic [3:0]       an_q, an_d;
   logic             blank_q, blank_d;
   logic             frame_tick_q, frame_tick_d;
   logic             tmr_clear, tmr_load, tmr_tc;
   logic [CNT_W-1:0] tmr_load_val;

   function automatic logic [1:0] lowest_set(input logic [3:0] mask);
      logic found;
      lowest_set = 2'd0;
      found      = 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
         if (mask[i] && !found) begin
            lowest_set = 2'(i);
            found      = 1'b1;
         end
      end
   endfunction

   // Step 4 lands back on cur, so the current digit wins only when it is the sole bit.
   function automatic logic [1:0] next_set(input logic [3:0] mask, input logic [1:0] cur);
      logic [1:0] idx;
      logic       found;
      next_set = cur;
      found    = 1'b0;
      for (int unsigned i = 1; i <= 4; i++) begin
         idx = cur + 2'(i);
         if (mask[idx] && !found) begin
            next_set = idx;
            found    = 1'b1;
         end
      end
   endfunction

   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      frame_tick_d = 1'b0;
      tmr_clear    = 1'b0;
      tmr_load     = 1'b0;
      tmr_load_val = '0;
      case (state_q)
         IDLE: begin
            tmr_clear = 1'b1;
            if (en && digit_mask != '0) begin
               sel_d        = lowest_set(digit_mask);
               state_d      = ENTRY_STATE;
               tmr_clear    = 1'b0;
               tmr_load     = 1'b1;
               tmr_load_val = ENTRY_LOAD;
            end
         end
         BLANK: begin
            if (!en) begin
               state_d   = IDLE;
               tmr_clear = 1'b1;
            end else if (tmr_tc) begin
               state_d      = DRIVE;
               tmr_load     = 1'b1;
               tmr_load_val = PHASE_LOAD;
            end
         end
         DRIVE: begin
            if (!en) begin
               state_d   = IDLE;
               tmr_clear = 1'b1;
            end else if (tmr_tc) begin
               if (digit_mask == '0) begin
                  state_d   = IDLE;
                  tmr_clear = 1'b1;
               end else begin
                  sel_d        = next_set(digit_mask, sel_q);
                  frame_tick_d = (sel_d <= sel_q);
                  state_d      = ENTRY_STATE;
                  tmr_load     = 1'b1;
                  tmr_load_val = ENTRY_LOAD;
               end
            end
         end
         default: begin
            state_d   = IDLE;
            tmr_clear = 1'b1;
         end
      endcase
      an_d    = (state_d == DRIVE) ? (4'b0001 << sel_d) : '0;
      blank_d = (an_d == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         sel_q        <= '0;
         an_q         <= '0;
         blank_q      <= 1'b1;
         frame_tick_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         an_q         <= an_d;
         blank_q      <= blank_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   scan_timer u_scan_timer (
      .clk      (clk),
      .rst      (rst),
      .clear    (tmr_clear),
      .load     (tmr_load),
      .load_val (tmr_load_val),
      .tc       (tmr_tc)
   );

   assign an         = an_q;
   assign sel        = sel_q;
   assign blank      = blank_q;
   assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench: two scanners (BLANK_CYCLES 2 and 0) share stimulus and are
// compared every cycle against an up-counting reference model.
module tb_display_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en  = 1'b0;
   logic [3:0] mask = 4'b0000;

   logic [3:0] an_a, an_b;
   logic [1:0] sel_a, sel_b;
   logic       blank_a, blank_b, tick_a, tick_b;

   int unsigned total = 0;
   int unsigned bad   = 0;

   always #5 clk = ~clk;

   display_scan_ctrl #(.PHASE_CYCLES(4), .BLANK_CYCLES(2)) dut_a (
      .clk(clk), .rst(rst), .en(en), .digit_mask(mask),
      .an(an_a), .sel(sel_a), .blank(blank_a), .frame_tick(tick_a)
   );

   display_scan_ctrl #(.PHASE_CYCLES(4), .BLANK_CYCLES(0)) dut_b (
      .clk(clk), .rst(rst), .en(en), .digit_mask(mask),
      .an(an_b), .sel(sel_b), .blank(blank_b), .frame_tick(tick_b)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // st: 0 idle, 1 blank, 2 drive; cnt counts elapsed cycles in the state
   typedef struct { int st; int cnt; int sel; int tick; } mdl_t;
   typedef struct { logic [3:0] an; logic [1:0] sel; logic blank; logic tick; } exp_t;

   mdl_t ma = '{default: 0};
   mdl_t mb = '{default: 0};
   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb;

   function automatic int first_from(input logic [3:0] mk, input int start);
      for (int k = 0; k < 4; k++)
         if (mk[(start + k) % 4]) return (start + k) % 4;
      return start;
   endfunction

   function automatic mdl_t step(input mdl_t m, input logic r, input logic e,
                                 input logic [3:0] mk, input int p, input int b);
      mdl_t n;
      int   nx;
      n = m;
      n.tick = 0;
      if (r) begin
         n.st = 0; n.cnt = 0; n.sel = 0;
      end else if (m.st == 0) begin
         if (e && mk != 4'b0000) begin
            n.sel = first_from(mk, 0); n.cnt = 0; n.st = (b == 0) ? 2 : 1;
         end
      end else if (!e) begin
         n.st = 0; n.cnt = 0;
      end else if (m.st == 1) begin
         if (m.cnt == b - 1) begin n.st = 2; n.cnt = 0; end
         else n.cnt = m.cnt + 1;
      end else begin
         if (m.cnt == p - 1) begin
            if (mk == 4'b0000) begin
               n.st = 0; n.cnt = 0;
            end else begin
               nx = first_from(mk, (m.sel + 1) % 4);
               n.tick = (nx <= m.sel) ? 1 : 0;
               n.sel = nx; n.cnt = 0; n.st = (b == 0) ? 2 : 1;
            end
         end else n.cnt = m.cnt + 1;
      end
      return n;
   endfunction

   function automatic exp_t to_exp(input mdl_t m);
      exp_t x;
      x.an    = (m.st == 2) ? 4'(1 << m.sel) : 4'h0;
      x.sel   = 2'(m.sel);
      x.blank = (x.an == 4'h0);
      x.tick  = (m.tick != 0);
      return x;
   endfunction

   always @(posedge clk) begin
      ma = step(ma, rst, en, mask, 4, 2);
      qa.push_back(to_exp(ma));
      mb = step(mb, rst, en, mask, 4, 0);
      qb.push_back(to_exp(mb));
   end

   always @(negedge clk) begin
      if (qa.size() != 0) begin
         ea = qa.pop_front();
         chk("a_an", an_a, ea.an);
         chk("a_sel", sel_a, ea.sel);
         chk("a_blank", blank_a, ea.blank);
         chk("a_tick", tick_a, ea.tick);
         chk("a_onehot0", $onehot0(an_a), 1);
      end
      if (qb.size() != 0) begin
         eb = qb.pop_front();
         chk("b_an", an_b, eb.an);
         chk("b_sel", sel_b, eb.sel);
         chk("b_blank", blank_b, eb.blank);
         chk("b_tick", tick_b, eb.tick);
         chk("b_onehot0", $onehot0(an_b), 1);
      end
   end

   logic [3:0] seq_an [27] = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h2,
                               4'h2, 4'h2, 4'h2, 4'h0, 4'h0, 4'h4, 4'h4, 4'h4, 4'h4,
                               4'h0, 4'h0, 4'h8, 4'h8, 4'h8, 4'h8, 4'h0, 4'h0, 4'h1};

   task automatic wait_drive_start(input logic [3:0] want, input string tag);
      logic [3:0] prev;
      bit         hit;
      hit  = 1'b0;
      prev = an_a;
      for (int c = 0; c < 80 && !hit; c++) begin
         @(negedge clk);
         if (an_a == want && prev != want) hit = 1'b1;
         prev = an_a;
      end
      chk({tag, "_reached"}, hit, 1);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_an", an_a, 0);
      chk("rst_blank", blank_a, 1);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // full 4-digit scan from reset, checked against literal sequence
      mask = 4'b1111;
      en   = 1'b1;
      for (int i = 0; i < 27; i++) begin
         @(negedge clk);
         chk("seq_an", an_a, seq_an[i]);
         chk("seq_tick", tick_a, (i == 24));
      end

      mask = 4'b0101;
      repeat (30) @(negedge clk);

      // mask change mid-drive of digit 0
      mask = 4'b1111;
      wait_drive_start(4'b0001, "d0_start");
      mask = 4'b0010;
      repeat (30) @(negedge clk);

      // en dropped on the 2nd drive cycle of digit 1
      mask = 4'b1111;
      wait_drive_start(4'b0010, "d1_start");
      @(negedge clk);
      en = 1'b0;
      @(negedge clk);
      chk("en_drop_an", an_a, 0);
      chk("en_drop_blank", blank_a, 1);
      chk("en_drop_sel", sel_a, 1);
      repeat (3) @(negedge clk);
      en = 1'b1;
      repeat (20) @(negedge clk);

      // reset mid-drive, then idle with an empty mask
      wait_drive_start(4'b0100, "d2_start");
      rst = 1'b1;
      mask = 4'b0000;
      @(negedge clk);
      chk("mid_rst_an", an_a, 0);
      chk("mid_rst_sel", sel_a, 0);
      chk("mid_rst_tick", tick_a, 0);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      chk("mask0_idle_an", an_a, 0);

      mask = 4'b0011;
      repeat (20) @(negedge clk);
      mask = 4'b0100;
      repeat (24) @(negedge clk);
      mask = 4'b0000;
      repeat (10) @(negedge clk);
      en = 1'b0;
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
